// File: rtl/chart_recorder.sv
// chart_recorder: captures lane key presses into one 4-bit chart RAM record per step
module chart_recorder #(
    parameter int STEP_TICKS = 112000000,
    parameter int ADDR_W     = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              key0,
    input  logic              key1,
    input  logic              key2,
    input  logic              key3,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [3:0]        wr_data,
    output logic              recording,
    output logic              done,
    output logic [ADDR_W:0]   length
);
    localparam int CNT_W = (STEP_TICKS > 2) ? $clog2(STEP_TICKS) : 1;
    localparam logic [CNT_W-1:0]  LAST_TICK = CNT_W'(STEP_TICKS - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    typedef enum logic [1:0] {IDLE, REC, FILL, DONE} state_t;

    state_t            state_q, state_d;
    logic [3:0]        sync1_q, sync1_d, sync2_q, sync2_d, sync3_q, sync3_d;
    logic [CNT_W-1:0]  step_cnt_q, step_cnt_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [3:0]        capture_q, capture_d;
    logic [ADDR_W:0]   length_q, length_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [3:0]        wr_data_q, wr_data_d;
    logic              done_q, done_d;
    logic [3:0]        key_edge;
    logic              final_tick, trig, at_last;

    assign key_edge   = sync2_q & ~sync3_q;
    assign final_tick = step_cnt_q == LAST_TICK;
    assign trig       = (state_q == REC) && (stop || final_tick);
    assign at_last    = ptr_q == LAST_ADDR;

    // Synchronizer chain plus one delayed copy for press-edge detection
    always_comb begin
        sync1_d = {key3, key2, key1, key0};
        sync2_d = sync1_q;
        sync3_d = sync2_q;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state: a step or flush write to the last address ends the take directly
    always_comb begin
        state_d = state_q;
        if (state_q == IDLE || state_q == DONE)
            state_d = start ? REC : state_q;
        else if (state_q == REC && trig)
            state_d = at_last ? DONE : (stop ? FILL : REC);
        else if (state_q == FILL && at_last)
            state_d = DONE;
    end

    // Datapath: step counting, capture accumulation, record and fill writes
    always_comb begin
        step_cnt_d = step_cnt_q;
        ptr_d      = ptr_q;
        capture_d  = capture_q;
        length_d   = length_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        if ((state_q == IDLE || state_q == DONE) && start) begin
            step_cnt_d = '0;
            ptr_d      = '0;
            capture_d  = '0;
            length_d   = '0;
        end else if (state_q == REC && trig) begin
            wr_en_d    = 1'b1;
            wr_addr_d  = ptr_q;
            wr_data_d  = capture_q | key_edge;
            capture_d  = '0;
            ptr_d      = at_last ? ptr_q : ptr_q + ADDR_W'(1);
            length_d   = length_q + (ADDR_W+1)'(1);
            step_cnt_d = '0;
        end else if (state_q == REC) begin
            capture_d  = capture_q | key_edge;
            step_cnt_d = step_cnt_q + CNT_W'(1);
        end else if (state_q == FILL) begin
            wr_en_d    = 1'b1;
            wr_addr_d  = ptr_q;
            wr_data_d  = 4'b0000;
            ptr_d      = at_last ? ptr_q : ptr_q + ADDR_W'(1);
        end
    end

    // done trails entry to DONE by one cycle so it follows the final write
    always_comb begin
        done_d = (state_q == DONE) && (state_d == DONE);
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            sync3_q    <= '0;
            step_cnt_q <= '0;
            ptr_q      <= '0;
            capture_q  <= '0;
            length_q   <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            done_q     <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            sync3_q    <= sync3_d;
            step_cnt_q <= step_cnt_d;
            ptr_q      <= ptr_d;
            capture_q  <= capture_d;
            length_q   <= length_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            done_q     <= done_d;
        end
    end

    // Output mapping
    always_comb begin
        wr_en     = wr_en_q;
        wr_addr   = wr_addr_q;
        wr_data   = wr_data_q;
        recording = state_q == REC;
        done      = done_q;
        length    = length_q;
    end
endmodule

// File: doc/chart_recorder.md
# chart_recorder

Records live key presses into a chart RAM as one 4-bit lane record per chart step. The format matches what the game controller plays back: bit *n* = note in lane *n*, consecutive addresses = consecutive steps. It sits between the four debounced lane keys and the write port of the chart RAM. Charts authored on the board can then be replayed by the existing playback path.

## Interface
- STEP_TICKS, 112000000: clock cycles per chart step; must match playback step period; ≥ 2
- ADDR_W, 11: chart RAM address width; DEPTH = 2**ADDR_W
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle pulse: begin new recording
- stop  in  1  one-cycle pulse: end recording early
- key0..key3  in  1 each  lane key levels, active-high, asynchronous to clk
- wr_en  out  1  RAM write strobe, one cycle per record
- wr_addr  out  ADDR_W  RAM address, valid while wr_en = 1
- wr_data  out  4  record {lane3,lane2,lane1,lane0}, valid while wr_en = 1
- recording  out  1  high in REC state
- done  out  1  high in DONE state
- length  out  ADDR_W+1  steps recorded in the current or last take; fill writes are excluded

## Operation
- Keys: 2-flop synchronizer per lane, then rising-edge detect on the synced level. A note is a press edge only. A held key contributes to one step only.
- capture[3:0] accumulates edges during the step. All of the following are cleared on entry to REC: capture, step_cnt, pointer ptr, length.
- States: IDLE, REC, FILL, DONE. All are left for IDLE by reset.
  - IDLE/DONE + start → REC. stop is ignored in both.
  - REC, step_cnt = STEP_TICKS-1 (final tick):
    - Write record = capture | edge_this_cycle to ptr.
    - Clear capture, ptr++, length++, step_cnt → 0.
    - Edges on the final tick count in the ending step. Edges one cycle later go to the next step.
  - REC + stop:
    - Flush-write capture | edge_this_cycle to ptr. The flush counts in length even if the data is 0.
    - If stop coincides with the final tick, only one write occurs.
    - Then go to FILL, or to DONE if that write went to DEPTH-1.
  - REC, write to address DEPTH-1 (step or flush) → DONE.
  - FILL: write 4'b0000 on consecutive cycles to ptr..DEPTH-1, one address per cycle. length is unchanged. After writing DEPTH-1 → DONE. This ensures no stale notes from a previous take remain.
  - start or stop in REC or FILL is ignored, except stop in REC as above.
- ptr never wraps. No write is ever issued beyond DEPTH-1.

## Timing
- Reset values: wr_en 0, wr_addr 0, wr_data 0, recording 0, done 0, length 0, capture 0, state IDLE.
- Asserting rst mid-REC or mid-FILL aborts immediately. No further writes are issued.
- All outputs are registered.
- start sampled at cycle t → recording = 1 and done = 0 at t+1. First step write (wr_en = 1, wr_addr = 0) at t+STEP_TICKS+1.
- Step writes are STEP_TICKS cycles apart.
- Key latency: key edge at the pin reaches capture in 3 cycles (2 sync + 1 edge).
- Trigger → write latency is 1 cycle: the write appears one cycle after the final tick, or one cycle after stop. length updates in the same cycle as its wr_en.
- recording falls in the same cycle as the final REC write's wr_en.
- FILL writes follow the flush write on the next cycles, with no gap.
- done rises the cycle after the last write: the last fill write, or the last REC write when no fill is needed.

## Test plan
Parameters: STEP_TICKS = 4, ADDR_W = 3.
- start; key0 held high for 3 steps → addr 0 data 0001, addrs 1, 2 data 0000. Held key makes a single note.
- start; key1 and key2 rising edges in step 0, separated by 1 cycle → addr 0 data 0110; length = 1 after that write.
- start; 3 full steps; key3 edge in the 4th step; stop mid-step → flush at addr 3 data 1000; FILL writes 0000 to addrs 4–7 on consecutive cycles; length = 4; done = 1 one cycle after the addr 7 write.
- start; no stop → 8 step writes at addrs 0–7, no fill writes; done = 1; recording = 0; length = 8. A second start restarts at addr 0 with length 0.
- Edge landing exactly on the final tick → counted in the ending step. Edge one cycle later → next step. stop on the final tick → exactly one write, then FILL.
- rst asserted mid-REC → all outputs 0 immediately; no writes follow. start issued during REC → ignored; the write cadence is unchanged.
